// File: rtl/tick_sequencer_pkg.sv
// Shared definitions for the tick sequencer and for display timing blocks.
// Holds the FSM state encoding, the run-mode constants and the default tick period.
package tick_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // 1 s at 100 MHz; display timing uses the same value.
    localparam int unsigned DEFAULT_TICK_CYCLES = 100000000;

endpackage

// File: rtl/tick_sequencer_prescaler.sv
// tick_prescaler: free-running period counter with clear and enable.
// at_last is high while the counter sits on its terminal value. The owner
// qualifies it with its own enable, so this output never depends on en.
module tick_prescaler #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] last_count,
    output logic             at_last
);

    logic [CNT_W-1:0] cnt_reg;

    assign at_last = (cnt_reg == last_count);

    // Period counter: clear wins over enable, and the counter wraps to 0 after last_count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (at_last) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer: divides clk into ticks and counts a run-time number of them.
// It supports one-shot and auto-reload modes, pause and abort.
// Optional feature: define TICK_SEQ_RT_PERIOD_EN to add a period_cycles input.
// That input is latched on start and sets the tick period; the values 0 and 1 act as 2.
module tick_sequencer
    import tick_sequencer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TICKS_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               mode,
    input  logic [TICKS_W-1:0] tick_target,
`ifdef TICK_SEQ_RT_PERIOD_EN
    input  logic [CNT_W-1:0]   period_cycles,
`endif
    output logic               busy,
    output logic               tick,
    output logic [TICKS_W-1:0] tick_count,
    output logic               flash,
    output logic               done_pulse,
    output logic               finished
);

    state_t             state_reg, state_next;
    logic [TICKS_W-1:0] count_reg, count_next;
    logic [TICKS_W-1:0] tgt_reg, tgt_next;
    logic [TICKS_W-1:0] count_inc;
    logic               mode_reg, mode_next;
    logic               flash_reg, flash_next;
    logic               tick_reg, tick_next;
    logic               done_reg, done_next;
    logic               pre_en, pre_clr, pre_at_last;
    logic [CNT_W-1:0]   last_count;

`ifdef TICK_SEQ_RT_PERIOD_EN
    logic [CNT_W-1:0] last_reg;
    logic [CNT_W-1:0] last_sel;

    // A period below 2 cannot produce a distinct tick, so it is clamped to 2.
    assign last_sel = (period_cycles < CNT_W'(2)) ? CNT_W'(1) : period_cycles - 1'b1;

    // Capture the requested period whenever a new run is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= CNT_W'(1);
        end else if (start && !abort) begin
            last_reg <= last_sel;
        end
    end

    assign last_count = last_reg;
`else
    assign last_count = CNT_W'(TICK_CYCLES - 1);
`endif

    tick_prescaler #(
        .CNT_W(CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (pre_en),
        .clr       (pre_clr),
        .last_count(last_count),
        .at_last   (pre_at_last)
    );

    assign count_inc = count_reg + 1'b1;

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            tgt_reg   <= '0;
            mode_reg  <= MODE_ONESHOT;
            flash_reg <= 1'b0;
            tick_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tgt_reg   <= tgt_next;
            mode_reg  <= mode_next;
            flash_reg <= flash_next;
            tick_reg  <= tick_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic. Priority is abort > start > pause. A pause freezes the
    // run on the same edge it is sampled, so a pause stretches the run by
    // exactly the number of cycles it is held high.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tgt_next   = tgt_reg;
        mode_next  = mode_reg;
        flash_next = flash_reg;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        pre_en     = 1'b0;
        pre_clr    = 1'b0;
        if (abort) begin
            state_next = IDLE;
            count_next = '0;
            flash_next = 1'b0;
            pre_clr    = 1'b1;
        end else if (start) begin
            tgt_next   = tick_target;
            mode_next  = mode;
            count_next = '0;
            flash_next = 1'b0;
            pre_clr    = 1'b1;
            if (tick_target == '0) begin
                // An empty run completes immediately and never ticks.
                done_next  = 1'b1;
                state_next = (mode == MODE_RELOAD) ? IDLE : DONE;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state_reg)
                RUN, PAUSED: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else begin
                        state_next = RUN;
                        pre_en     = 1'b1;
                        if (pre_at_last) begin
                            tick_next  = 1'b1;
                            flash_next = ~flash_reg;
                            if (count_inc == tgt_reg) begin
                                done_next = 1'b1;
                                if (mode_reg == MODE_ONESHOT) begin
                                    count_next = tgt_reg;
                                    state_next = DONE;
                                end else begin
                                    count_next = '0;
                                end
                            end else begin
                                count_next = count_inc;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
    assign finished   = (state_reg == DONE);
    assign tick       = tick_reg;
    assign done_pulse = done_reg;
    assign tick_count = count_reg;
    assign flash      = flash_reg;

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer with TICK_CYCLES=4.
// The directed tasks compare against absolute cycle numbers. The random task
// compares against a countdown-based behavioural model.
module tb_tick_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] tick_target = 8'd0;
`ifdef TICK_SEQ_RT_PERIOD_EN
    logic [7:0] period_cycles = 8'd4;
`endif
    logic       busy, tick, flash, done_pulse, finished;
    logic [7:0] tick_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Behavioural model: a run is "active", possibly "frozen". It counts down
    // the cycles left until the next tick.
    bit m_active, m_frozen, m_done, m_tick, m_donep, m_flash, m_mode;
    int m_left, m_cnt, m_tgt, m_period;

    tick_sequencer #(
        .TICK_CYCLES(P),
        .CNT_W      (8),
        .TICKS_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .mode       (mode),
        .tick_target(tick_target),
`ifdef TICK_SEQ_RT_PERIOD_EN
        .period_cycles(period_cycles),
`endif
        .busy       (busy),
        .tick       (tick),
        .tick_count (tick_count),
        .flash      (flash),
        .done_pulse (done_pulse),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        m_tick  = 0;
        m_donep = 0;
        if (rst) begin
            m_active = 0; m_frozen = 0; m_done = 0;
            m_cnt = 0; m_flash = 0;
        end else if (abort) begin
            m_active = 0; m_frozen = 0; m_done = 0;
            m_cnt = 0; m_flash = 0;
        end else if (start) begin
            m_tgt  = tick_target;
            m_mode = mode;
            m_cnt  = 0;
            m_flash = 0;
`ifdef TICK_SEQ_RT_PERIOD_EN
            m_period = (period_cycles < 2) ? 2 : int'(period_cycles);
`else
            m_period = P;
`endif
            m_left = m_period;
            m_frozen = 0;
            if (m_tgt == 0) begin
                m_donep  = 1;
                m_active = 0;
                m_done   = (mode == 1'b0);
            end else begin
                m_active = 1;
                m_done   = 0;
            end
        end else if (m_active) begin
            if (pause) begin
                m_frozen = 1;
            end else begin
                m_frozen = 0;
                m_left--;
                if (m_left == 0) begin
                    m_left  = m_period;
                    m_tick  = 1;
                    m_flash = !m_flash;
                    m_cnt++;
                    if (m_cnt == m_tgt) begin
                        m_donep = 1;
                        if (m_mode == 1'b0) begin
                            m_active = 0;
                            m_done   = 1;
                        end else begin
                            m_cnt = 0;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs that the edge samples,
    // then settle 1 time unit past the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        total_cnt++;
        if ({busy, tick, flash, done_pulse, finished, tick_count} !== 13'd0)
            $display("FAIL reset_outputs got=%b want=0", {busy, tick, flash, done_pulse, finished, tick_count});
        else pass_cnt++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_oneshot();
        bit exp_t;
        tick_target = 8'd3; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            exp_t = (k % 4 == 0) && (k <= 12);
            total_cnt++;
            if (tick !== exp_t) $display("FAIL oneshot_tick k=%0d got=%b want=%b", k, tick, exp_t);
            else pass_cnt++;
            total_cnt++;
            if (done_pulse !== (k == 12)) $display("FAIL oneshot_done k=%0d got=%b want=%b", k, done_pulse, k == 12);
            else pass_cnt++;
            if (exp_t) begin
                total_cnt++;
                if (flash !== ((k / 4) % 2 == 1)) $display("FAIL oneshot_flash k=%0d got=%b", k, flash);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({finished, busy, tick_count} !== {1'b1, 1'b0, 8'd3})
            $display("FAIL oneshot_end fin/busy/cnt got=%b/%b/%0d want=1/0/3", finished, busy, tick_count);
        else pass_cnt++;
    endtask

    task automatic test_reload();
        tick_target = 8'd2; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            total_cnt++;
            if (done_pulse !== (k % 8 == 0)) $display("FAIL reload_done k=%0d got=%b", k, done_pulse);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL reload_busy k=%0d got=%b want=1", k, busy);
            else pass_cnt++;
            if (k % 4 == 0) begin
                total_cnt++;
                if (tick_count !== 8'((k / 4) % 2)) $display("FAIL reload_count k=%0d got=%0d want=%0d", k, tick_count, (k / 4) % 2);
                else pass_cnt++;
            end
        end
        abort = 1'b1; cyc(); abort = 1'b0;
    endtask

    task automatic test_pause();
        bit exp_t;
        tick_target = 8'd3; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            pause = (k >= 3 && k <= 7);
            cyc();
            exp_t = (k == 9 || k == 13 || k == 17);
            total_cnt++;
            if (tick !== exp_t) $display("FAIL pause_tick k=%0d got=%b want=%b", k, tick, exp_t);
            else pass_cnt++;
            total_cnt++;
            if (done_pulse !== (k == 17)) $display("FAIL pause_done k=%0d got=%b", k, done_pulse);
            else pass_cnt++;
            total_cnt++;
            if (busy !== (k < 17)) $display("FAIL pause_busy k=%0d got=%b want=%b", k, busy, k < 17);
            else pass_cnt++;
        end
        pause = 1'b0;
    endtask

    task automatic test_abort();
        tick_target = 8'd3; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        total_cnt++;
        if ({tick_count, flash} !== {8'd1, 1'b1}) $display("FAIL abort_pre cnt/flash got=%0d/%b want=1/1", tick_count, flash);
        else pass_cnt++;
        abort = 1'b1; cyc(); abort = 1'b0;
        total_cnt++;
        if ({busy, tick, flash, done_pulse, finished, tick_count} !== 13'd0)
            $display("FAIL abort_outputs got=%b want=0", {busy, tick, flash, done_pulse, finished, tick_count});
        else pass_cnt++;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        total_cnt++;
        if ({busy, finished, done_pulse} !== 3'b000) $display("FAIL abort_start got=%b want=000", {busy, finished, done_pulse});
        else pass_cnt++;
    endtask

    task automatic test_zero_target();
        tick_target = 8'd0; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++;
        if ({done_pulse, finished, tick, busy} !== 4'b1100) $display("FAIL zero_oneshot done/fin/tick/busy got=%b want=1100", {done_pulse, finished, tick, busy});
        else pass_cnt++;
        repeat (6) begin
            cyc();
            total_cnt++;
            if ({done_pulse, tick, finished} !== 3'b001) $display("FAIL zero_after got=%b want=001", {done_pulse, tick, finished});
            else pass_cnt++;
        end
        mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++;
        if ({done_pulse, finished, tick, busy} !== 4'b1000) $display("FAIL zero_reload done/fin/tick/busy got=%b want=1000", {done_pulse, finished, tick, busy});
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        tick_target = 8'd5; mode = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        total_cnt++;
        if ({busy, flash, tick_count} !== {1'b1, 1'b1, 8'd1}) $display("FAIL midrun_pre got=%b", {busy, flash, tick_count});
        else pass_cnt++;
        rst = 1'b1; cyc(); rst = 1'b0;
        total_cnt++;
        if ({busy, tick, flash, done_pulse, finished, tick_count} !== 13'd0)
            $display("FAIL midrun_reset got=%b want=0", {busy, tick, flash, done_pulse, finished, tick_count});
        else pass_cnt++;
    endtask

`ifdef TICK_SEQ_RT_PERIOD_EN
    task automatic test_rt_period();
        period_cycles = 8'd6; tick_target = 8'd2; mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            total_cnt++;
            if (tick !== (k == 6 || k == 12)) $display("FAIL period6_tick k=%0d got=%b", k, tick);
            else pass_cnt++;
        end
        period_cycles = 8'd1; tick_target = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            total_cnt++;
            if (tick !== (k % 2 == 0)) $display("FAIL period1_tick k=%0d got=%b", k, tick);
            else pass_cnt++;
        end
        period_cycles = 8'd4;
    endtask
`endif

    task automatic test_random();
        logic [12:0] got, want;
        abort = 1'b1; cyc(); abort = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            start = ($urandom % 32) == 0;
            abort = ($urandom % 100) == 0;
            if (($urandom % 16) == 0) pause = ~pause;
            if (start) begin
                tick_target = 8'($urandom_range(0, 5));
                mode = 1'($urandom % 2);
`ifdef TICK_SEQ_RT_PERIOD_EN
                period_cycles = 8'($urandom_range(0, 7));
`endif
            end
            cyc();
            got  = {busy, tick, flash, done_pulse, finished, tick_count};
            want = {m_active, m_tick, m_flash, m_donep, m_done, 8'(m_cnt)};
            total_cnt++;
            if (got !== want) $display("FAIL random n=%0d busy,tick,flash,done,fin,cnt got=%b want=%b", n, got, want);
            else pass_cnt++;
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_pause();
        test_abort();
        test_zero_target();
        test_reset_midrun();
`ifdef TICK_SEQ_RT_PERIOD_EN
        test_rt_period();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
